// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// and a single-port DataMemory. Each line holds one 32-bit word.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   address, writeData       CPU byte address (bits [1:0] ignored), store data
//   memRead, memWrite        CPU load / store request (both high acts as a store)
//   readData, stall          CPU load data and hold request (combinational)
//   memAddress, memWriteData DataMemory address / write data, registered
//   memReadEn, memWriteEn    DataMemory strobes, decoded from the state register
//   memReadData, memReady    DataMemory read data / access complete this cycle
//   hitCount, missCount      16-bit wrapping read hit / miss counters
module dcache_controller #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    output logic [31:0] readData,
    output logic        stall,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memReadEn,
    output logic        memWriteEn,
    input  logic [31:0] memReadData,
    input  logic        memReady,
    output logic [15:0] hitCount,
    output logic [15:0] missCount
);

    localparam int unsigned LINES   = 2 ** INDEX_BITS;
    localparam int unsigned TAG_LSB = INDEX_BITS + 2;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_MISS  = 2'd1,
        WRITE_THRU = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      data_arr [LINES];
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [LINES-1:0] valid_q;

    logic [INDEX_BITS-1:0] cpu_idx, fill_idx, line_idx;
    logic [TAG_W-1:0]      cpu_tag, fill_tag, line_tag;
    logic [31:0]           line_data;
    logic                  line_we;
    logic                  cpu_hit;
    logic                  hit_inc, miss_inc;
    logic                  ld_addr, ld_wdata;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];

    // CPU-side lookup uses the live address; the fill uses the latched miss address.
    assign cpu_idx  = address[INDEX_BITS+1:2];
    assign cpu_tag  = address[31:TAG_LSB];
    assign fill_idx = memAddress[INDEX_BITS+1:2];
    assign fill_tag = memAddress[31:TAG_LSB];
    assign cpu_hit  = valid_q[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);

    assign memReadEn  = (state_q == READ_MISS);
    assign memWriteEn = (state_q == WRITE_THRU);

    // Next-state, CPU response and update controls.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        readData  = '0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        ld_addr   = 1'b0;
        ld_wdata  = 1'b0;
        line_we   = 1'b0;
        line_idx  = cpu_idx;
        line_tag  = cpu_tag;
        line_data = writeData;

        case (state_q)
            IDLE: begin
                if (memWrite) begin
                    // Store wins over a simultaneous load; update the line only on hit.
                    stall    = 1'b1;
                    ld_addr  = 1'b1;
                    ld_wdata = 1'b1;
                    line_we  = cpu_hit;
                    state_d  = WRITE_THRU;
                end else if (memRead) begin
                    if (cpu_hit) begin
                        readData = data_arr[cpu_idx];
                        hit_inc  = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        ld_addr  = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = READ_MISS;
                    end
                end
            end

            READ_MISS: begin
                stall = ~memReady;
                if (memReady) begin
                    readData  = memReadData;
                    line_we   = 1'b1;
                    line_idx  = fill_idx;
                    line_tag  = fill_tag;
                    line_data = memReadData;
                    state_d   = IDLE;
                end
            end

            WRITE_THRU: begin
                stall = ~memReady;
                if (memReady) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, valid bits, counters and memory-side registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            hitCount     <= '0;
            missCount    <= '0;
            memAddress   <= '0;
            memWriteData <= '0;
        end else begin
            state_q <= state_d;
            if (line_we) begin
                valid_q[line_idx] <= 1'b1;
            end
            if (hit_inc) begin
                hitCount <= hitCount + 16'd1;
            end
            if (miss_inc) begin
                missCount <= missCount + 16'd1;
            end
            if (ld_addr) begin
                memAddress <= {address[31:2], 2'b00};
            end
            if (ld_wdata) begin
                memWriteData <= writeData;
            end
        end
    end

    // Line storage has no reset; a reset cycle never writes it.
    always_ff @(posedge clk) begin
        if (rst && line_we) begin
            data_arr[line_idx] <= line_data;
            tag_arr[line_idx]  <= line_tag;
        end
    end

endmodule
